// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings, default bit timing and the
// parity helper. The parity-enable switch is the macro UART_RX_PARITY_EN;
// when it is defined the PARITY state exists and frames carry an even-parity bit.
package uart_defs;

  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Clearable bit-cycle counter with half-bit and full-bit terminal flags.
// The count holds at the full-bit terminal value until cleared, so it never wraps.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_hit,
  output logic full_hit
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  // Count clock cycles within the current bit; clear restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (count != FULL_LAST) begin
      count <= count + 16'd1;
    end else begin
      count <= count;
    end
  end

  assign half_hit = (count == HALF_LAST);
  assign full_hit = (count == FULL_LAST);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchronizer, bit-timed sampling FSM, registered
// status pulses. Optional even parity is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fsm
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  logic        rx_meta, rx_s;
  uart_state_t state, state_next;
  logic [7:0]  shift, shift_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  data_next;
  logic        dv_next, fe_next;
  logic        timer_clr, half_hit, full_hit;
`ifdef UART_RX_PARITY_EN
  logic        par_bad, par_bad_next, pe_next;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .clr      (timer_clr),
    .half_hit (half_hit),
    .full_hit (full_hit)
  );

  // Bring the asynchronous line into the clock domain; resets to idle-high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register; busy is registered from the next state so it tracks state exactly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

  // Next-state decision from the synchronized line and bit-timer flags.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (!rx_s) state_next = ST_START; else state_next = ST_IDLE;
      ST_START:     if (half_hit) state_next = rx_s ? ST_IDLE : ST_DATA;
                    else state_next = ST_START;
`ifdef UART_RX_PARITY_EN
      ST_DATA:      if (full_hit && idx == 3'd7) state_next = ST_PARITY;
                    else state_next = ST_DATA;
      ST_PARITY:    if (full_hit) state_next = ST_STOP; else state_next = ST_PARITY;
`else
      ST_DATA:      if (full_hit && idx == 3'd7) state_next = ST_STOP;
                    else state_next = ST_DATA;
`endif
      ST_STOP:      if (full_hit) state_next = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    else state_next = ST_STOP;
      ST_WAIT_HIGH: if (rx_s) state_next = ST_IDLE; else state_next = ST_WAIT_HIGH;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Per-state datapath updates and next values of the registered outputs.
  always_comb begin
    timer_clr  = 1'b0;
    shift_next = shift;
    idx_next   = idx;
    data_next  = data_out;
    dv_next    = 1'b0;
    fe_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad;
    pe_next      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        timer_clr = 1'b1;
        idx_next  = 3'd0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = 1'b0;
`endif
      end
      ST_START: begin
        if (half_hit) begin
          timer_clr = 1'b1;
          idx_next  = 3'd0;
        end
      end
      ST_DATA: begin
        if (full_hit) begin
          timer_clr       = 1'b1;
          shift_next[idx] = rx_s;
          // Index saturates at 7; the exit is taken there instead of wrapping.
          if (idx != 3'd7) idx_next = idx + 3'd1;
          else idx_next = idx;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (full_hit) begin
          timer_clr    = 1'b1;
          par_bad_next = (rx_s != even_parity(shift));
        end
      end
`endif
      ST_STOP: begin
        if (full_hit) begin
          timer_clr = 1'b1;
          if (!rx_s) begin
            fe_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            pe_next = 1'b1;
`endif
          end else begin
            dv_next   = 1'b1;
            data_next = shift;
          end
        end
      end
      ST_WAIT_HIGH: timer_clr = 1'b0;
      default:      timer_clr = 1'b1;
    endcase
  end

  // Datapath and status-pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift      <= 8'h00;
      idx        <= 3'd0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shift      <= shift_next;
      idx        <= idx_next;
      data_out   <= data_next;
      data_valid <= dv_next;
      frame_err  <= fe_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch flag for the frame in flight and its error pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_next;
      parity_err <= pe_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed scenarios plus random frames,
// checked against a frame-level reference model. Honours UART_RX_PARITY_EN.
module tb_uart_rx_fsm;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, busy, pe_w;

  int errors = 0;
  int checks = 0;

  // Reference model state (frame-level expectations).
  logic [7:0] exp_q[$];
  int         exp_fe = 0, exp_pe = 0;
  logic [7:0] exp_dout = 8'h00;

  // Observed events.
  logic [7:0] got_q[$];
  int         n_fe = 0, n_pe = 0, overlap = 0, longp = 0;
  logic       dv_q = 1'b0, fe_q = 1'b0, pe_q = 1'b0;

`ifdef UART_RX_PARITY_EN
  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy), .parity_err(pe_w));
`else
  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy));
  assign pe_w = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Record output pulses away from the active edge.
  always @(negedge CLK) begin
    if (data_valid) got_q.push_back(data_out);
    if (frame_err) n_fe++;
    if (pe_w) n_pe++;
    if (int'(data_valid) + int'(frame_err) + int'(pe_w) > 1) overlap++;
    if ((data_valid && dv_q) || (frame_err && fe_q) || (pe_w && pe_q)) longp++;
    dv_q = data_valid;
    fe_q = frame_err;
    pe_q = pe_w;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge CLK);
  endtask

  // Frame-level rules: low stop -> framing error; bad parity -> parity error;
  // otherwise the byte is delivered and becomes the held output value.
  task automatic model_frame(input logic [7:0] b, input logic stop_low, input logic par_ok);
    if (stop_low) exp_fe++;
    else if (!par_ok) exp_pe++;
    else begin
      exp_q.push_back(b);
      exp_dout = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_low, input int low_cycles,
                            input logic par_bit);
    logic par_ok;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = (par_bit == ^b);
`endif
    model_frame(b, stop_low, par_ok);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit, CPB);
`endif
    if (stop_low) drive_bit(1'b0, low_cycles);
    drive_bit(1'b1, CPB);
  endtask

  // Let the line idle, then compare everything observed with the model.
  task automatic verify(input string tag);
    logic [7:0] g, e;
    drive_bit(1'b1, 2 * CPB);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_byte"}, 32'(g), 32'(e));
    end
    check({tag, "_extra_valid"}, 32'(got_q.size()), 32'd0);
    check({tag, "_missing_valid"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_frame_err_cnt"}, 32'(n_fe), 32'(exp_fe));
    check({tag, "_parity_err_cnt"}, 32'(n_pe), 32'(exp_pe));
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_dout));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       sl, pb;
    int         guard;

    @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    drive_bit(1'b1, 2 * CPB);
    check("idle_busy", 32'(busy), 32'd0);

    // Single frame 0xA5.
    send_frame(8'hA5, 1'b0, 0, ^8'hA5);
    verify("a5");

    // Back-to-back 0x00 then 0xFF, no idle gap.
    send_frame(8'h00, 1'b0, 0, 1'b0);
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    verify("b2b");

    // Five-cycle low glitch must be rejected.
    drive_bit(1'b0, 5);
    check("glitch_busy_rise", 32'(busy), 32'd1);
    rx = 1'b1;
    guard = 0;
    while (busy && guard < 8) begin
      @(negedge CLK);
      guard++;
    end
    check("glitch_busy_drop", 32'(busy), 32'd0);
    verify("glitch");

    // Framing error with stop held low for 40 cycles, then a good frame.
    send_frame(8'h3C, 1'b1, 40, ^8'h3C);
    check("ferr_data_out_held", 32'(data_out), 32'hFF);
    send_frame(8'h11, 1'b0, 0, ^8'h11);
    verify("ferr");

    // Reset in the middle of data bit 4 of 0x55.
    b = 8'h55;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
    drive_bit(b[4], CPB / 2);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    exp_dout = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h96, 1'b0, 0, ^8'h96);
    verify("rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 0, 1'b0);
    send_frame(8'h07, 1'b0, 0, 1'b1);
    verify("parity");
`endif

    // Random frames with occasional framing/parity faults and random gaps.
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      sl = ($urandom_range(0, 5) == 0);
      pb = ^b;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 4) == 0) pb = ~pb;
`endif
      send_frame(b, sl, $urandom_range(CPB, 3 * CPB), pb);
      drive_bit(1'b1, CPB * $urandom_range(0, 2));
    end
    verify("rand");

    check("pulse_exclusive", 32'(overlap), 32'd0);
    check("pulse_single_cycle", 32'(longp), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: CLK cycles per serial bit; legal range is even values 4..65534.
REQ-002 Port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 Port RST  input  1  reset, asynchronous, active-high.
REQ-004 Port rx  input  1  serial line; idle high (floating line is pulled up externally); asynchronous to CLK.
REQ-005 Port data_out  output  8  last correctly received byte.
REQ-006 Port data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-007 Port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 Port busy  output  1  high whenever state is not IDLE.
REQ-009 Port parity_err  output  1  one-cycle pulse on parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
REQ-011 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-012 IDLE: rx_s==0 -> START, with the bit-cycle counter cleared.
REQ-013 START: at counter==CLKS_PER_BIT/2-1, resample rx_s; 0 -> DATA (counter cleared, bit index 0); 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: sample rx_s at counter==CLKS_PER_BIT-1 into shift bit [index], LSB first; after index 7 -> PARITY or STOP.
REQ-015 The 3-bit bit index SHALL be cleared on entry to DATA and SHALL NOT wrap silently; exit is decided at index==7.
REQ-016 STOP: sample at counter==CLKS_PER_BIT-1; 1 -> data_out<=shift register, data_valid=1 for the next cycle, -> IDLE; 0 -> frame_err=1 for one cycle, data_out unchanged, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s==1 (break condition), then -> IDLE.
REQ-018 A new start bit detected in the cycle immediately after STOP->IDLE SHALL be accepted; back-to-back frames need no idle gap.
REQ-019 data_valid, frame_err and parity_err SHALL be registered, mutually exclusive, and never high for more than one cycle per frame.
REQ-020 data_out SHALL hold its value between frames and on error frames.

Reset
REQ-021 RST high SHALL immediately force state=IDLE, counters=0, data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, busy=0, and synchronizer flops=1.
REQ-022 RST asserted mid-frame SHALL discard the partial byte; after release the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: one even-parity bit follows data bit 7 and is sampled in PARITY; on mismatch the frame SHALL complete through STOP, parity_err pulses instead of data_valid, and data_out stays unchanged.
REQ-024 Macro undefined: no PARITY state and no parity_err port; the frame is start + 8 data + stop.

Structure
REQ-025 Shared package/include uart_defs SHALL hold the state encodings, the default CLKS_PER_BIT, and the parity-enable define, also used by the transmitter.
REQ-026 Sub-module uart_bit_timer SHALL provide the clearable bit-cycle counter with half-bit and full-bit terminal flags.

Verification
REQ-027 CLKS_PER_BIT=16, frame 0xA5 driven on rx -> data_out=8'hA5, one data_valid pulse, busy low afterwards.
REQ-028 Two back-to-back frames 0x00 then 0xFF with no gap -> two data_valid pulses, data_out=8'h00 then 8'hFF.
REQ-029 rx low pulse of 5 cycles -> no pulse on any output; state returns to IDLE; busy drops within 8 cycles of rx returning high.
REQ-030 Frame 0x3C with stop bit held low for 40 cycles -> frame_err pulse, data_out unchanged, next valid frame 0x11 received correctly.
REQ-031 RST pulsed during data bit 4 of 0x55 -> all outputs 0 immediately; following frame 0x96 gives data_out=8'h96.
REQ-032 With UART_RX_PARITY_EN, frame 0x07 with wrong parity bit 0 -> parity_err pulse, no data_valid; frame 0x07 with parity bit 1 -> data_valid pulse, data_out=8'h07.
